pipe_ctrl_regs: RTL and testbench
=================================

Name: pipe_ctrl_regs

Overview:
Pipeline control-register chain that produces the hazard and forwarding feedback consumed by the pipelined control unit. It captures the decode-stage control word and destination register number each cycle, then propagates them through the ID/EXE, EXE/MEM and MEM/WB boundaries. On a load-use stall it inserts a bubble. After a taken control transfer it generates the squash flag `ebubble`. Two saturating hazard counters are kept for performance debug.

Parameters:
- RW, 5, register-number width.
- CW, 16, hazard counter width.
- LINK_REG, 31, destination register number forced for jal.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- d_wreg  in  1  decode: instruction writes the register file.
- d_m2reg  in  1  decode: writeback data comes from memory (load).
- d_wmem  in  1  decode: memory write (store).
- d_regrt  in  1  decode: destination is rt rather than rd.
- d_jal  in  1  decode: jal; destination is LINK_REG.
- d_aluc  in  4  decode ALU control.
- d_aluimm  in  1  decode: ALU B operand is the immediate.
- d_shift  in  1  decode: ALU A operand is shamt.
- d_rt  in  RW  decode rt field.
- d_rd  in  RW  decode rd field.
- d_pcsource  in  2  decode PC select; already gated by the control unit.
- wpcir  in  1  0 means a load-use stall is in progress this cycle.
- ewreg, em2reg, ewmem  out  1 each  ID/EXE control bits.
- ealuc  out  4  ID/EXE ALU control.
- ealuimm, eshift, ejal  out  1 each  ID/EXE operand-select bits.
- ern  out  RW  ID/EXE destination register.
- ebubble  out  1  the instruction now in ID is in the shadow of a taken transfer.
- mwreg, mm2reg, mwmem  out  1 each  EXE/MEM control bits.
- mrn  out  RW  EXE/MEM destination register.
- wwreg, wm2reg  out  1 each  MEM/WB control bits.
- wrn  out  RW  MEM/WB destination register.
- stall_cnt  out  CW  number of cycles with wpcir=0; saturating.
- bubble_cnt  out  CW  number of cycles with ebubble=1; saturating.

Behaviour:
- Reset: all outputs are 0, including counters and ebubble. Reset is asynchronous; assertion mid-operation clears every stage in the same instant.
- Destination select (combinational, ID): d_rn = d_jal ? LINK_REG : (d_regrt ? d_rt : d_rd).
- ID/EXE, every rising edge:
  - If wpcir=1: load all e* fields from the d* inputs, ern<=d_rn, and ebubble<=|d_pcsource.
  - If wpcir=0 (bubble): ewreg, em2reg, ewmem, ejal, ealuimm and eshift<=0; ealuc<=0; ern<=0; ebubble<=0.
  - Rationale: the control unit already forces the squashed instruction's pcsource to 0, so back-to-back ebubble cannot occur.
- EXE/MEM, every edge, unconditional: mwreg<=ewreg, mm2reg<=em2reg, mwmem<=ewmem, mrn<=ern. A bubble therefore flows down the pipe as all-zero.
- MEM/WB, every edge, unconditional: wwreg<=mwreg, wm2reg<=mm2reg, wrn<=mrn.
- Latency: one cycle per stage; a decode field reaches w* three edges after it is presented.
- No stage holds its value; only the PC and IF/ID registers (outside this block) hold on a stall.
- ern is not forced to 0 when d_wreg=0. The control unit qualifies forwarding with ewreg/mwreg, and the 0-register test covers $zero.
- Counters:
  - stall_cnt increments on each edge where wpcir=0.
  - bubble_cnt increments on each edge where ebubble=1 (the pre-edge value).
  - Both stick at all-ones with no wrap.
  - Both can increment on the same edge.
- X-safety: d_* inputs with X values while wpcir=0 must not propagate.

Decomposition:
- Shared package cpu_pkg holds:
  - RW and LINK_REG constants.
  - A4-bit ALU control encodings (ADD 0000, SUB x100, AND x001, OR x101, XOR x010, LUI x110, SLL 0011, SRL 0111, SRA 1111).
  - Packed struct ctrl_t {wreg, m2reg, wmem, jal, aluimm, shift, aluc}.
  - Constant CTRL_BUBBLE = all-zero ctrl_t.
- One sub-module is natural: sat_counter (parameter CW; inputs clock, reset, inc; output count), instantiated twice.

Test Plan:
- Reset mid-stream: drive d_wreg=1, d_rd=7 for 3 cycles, then assert reset asynchronously between edges -> every output reads 0 immediately, before the next edge.
- Propagation: d_wreg=1, d_regrt=1, d_rt=9, wpcir=1 for 1 cycle, then zeros -> ern=9, ewreg=1 after edge 1; mrn=9 after edge 2; wrn=9, wwreg=1 after edge 3.
- jal destination: d_jal=1, d_wreg=1, d_rd=4, d_rt=5, d_pcsource=2'b11 -> ern=31, ejal=1, ebubble=1 after one edge; bubble_cnt=1 after the next edge.
- Load-use stall: lw with d_m2reg=1, d_rt=8, then wpcir=0 for 1 cycle while d_wreg=1, d_rd=3 -> edge 2 gives ewreg=0, ern=0, mm2reg=1, mrn=8; stall_cnt=1.
- Stall overrides branch: wpcir=0 with d_pcsource=2'b01 -> ebubble=0 and all e* fields 0.
- Saturation with CW=4: hold wpcir=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; bubble_cnt unchanged at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-number constants, ALU control
// encodings and the per-stage pipeline control word.
package cpu_pkg;

    localparam int RW       = 5;
    localparam int LINK_REG = 31;

    // ALU control encodings; the don't-care upper bit is written as 0.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Control word carried across the ID/EXE boundary.
    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic       aluimm;
        logic       shift;
        logic [3:0] aluc;
    } ctrl_t;

    // A bubble is an all-zero control word: it writes nothing anywhere.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_regs_sat_counter.sv
// Saturating up-counter used for the pipeline hazard statistics.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Pipeline control-register chain: carries the decode control word and
// destination register through ID/EXE, EXE/MEM and MEM/WB, inserts a
// bubble on load-use stalls, flags branch-shadow squashes and keeps two
// saturating hazard counters.
module pipe_ctrl_regs #(
    parameter int RW       = cpu_pkg::RW,
    parameter int CW       = 16,
    parameter int LINK_REG = cpu_pkg::LINK_REG
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          d_wreg,
    input  logic          d_m2reg,
    input  logic          d_wmem,
    input  logic          d_regrt,
    input  logic          d_jal,
    input  logic [3:0]    d_aluc,
    input  logic          d_aluimm,
    input  logic          d_shift,
    input  logic [RW-1:0] d_rt,
    input  logic [RW-1:0] d_rd,
    input  logic [1:0]    d_pcsource,
    input  logic          wpcir,
    output logic          ewreg,
    output logic          em2reg,
    output logic          ewmem,
    output logic [3:0]    ealuc,
    output logic          ealuimm,
    output logic          eshift,
    output logic          ejal,
    output logic [RW-1:0] ern,
    output logic          ebubble,
    output logic          mwreg,
    output logic          mm2reg,
    output logic          mwmem,
    output logic [RW-1:0] mrn,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [RW-1:0] wrn,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt
);

    import cpu_pkg::*;

    ctrl_t         w_d_ctrl;
    logic [RW-1:0] w_d_rn;

    ctrl_t         r_e_ctrl;
    logic [RW-1:0] r_e_rn;
    logic          r_ebubble;

    logic          r_m_wreg;
    logic          r_m_m2reg;
    logic          r_m_wmem;
    logic [RW-1:0] r_m_rn;

    logic          r_w_wreg;
    logic          r_w_m2reg;
    logic [RW-1:0] r_w_rn;

    // Pack the decode control word and pick the destination register.
    always_comb begin
        // NOTE: every combinational output gets a value on every path,
        // otherwise synthesis infers a latch.
        w_d_ctrl        = CTRL_BUBBLE;
        w_d_ctrl.wreg   = d_wreg;
        w_d_ctrl.m2reg  = d_m2reg;
        w_d_ctrl.wmem   = d_wmem;
        w_d_ctrl.jal    = d_jal;
        w_d_ctrl.aluimm = d_aluimm;
        w_d_ctrl.shift  = d_shift;
        w_d_ctrl.aluc   = d_aluc;
        w_d_rn          = d_jal ? RW'(LINK_REG) : (d_regrt ? d_rt : d_rd);
    end

    // ID/EXE: load decode fields, or force an all-zero bubble on a stall so
    // that nothing from the stalled decode slot (even X) leaks forward.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_e_ctrl  <= CTRL_BUBBLE;
            r_e_rn    <= '0;
            r_ebubble <= 1'b0;
        end else if (wpcir) begin
            r_e_ctrl  <= w_d_ctrl;
            r_e_rn    <= w_d_rn;
            r_ebubble <= |d_pcsource;
        end else begin
            r_e_ctrl  <= CTRL_BUBBLE;
            r_e_rn    <= '0;
            r_ebubble <= 1'b0;
        end
    end

    // EXE/MEM and MEM/WB: unconditional one-cycle shift, never holding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m_wreg  <= 1'b0;
            r_m_m2reg <= 1'b0;
            r_m_wmem  <= 1'b0;
            r_m_rn    <= '0;
            r_w_wreg  <= 1'b0;
            r_w_m2reg <= 1'b0;
            r_w_rn    <= '0;
        end else begin
            r_m_wreg  <= r_e_ctrl.wreg;
            r_m_m2reg <= r_e_ctrl.m2reg;
            r_m_wmem  <= r_e_ctrl.wmem;
            r_m_rn    <= r_e_rn;
            r_w_wreg  <= r_m_wreg;
            r_w_m2reg <= r_m_m2reg;
            r_w_rn    <= r_m_rn;
        end
    end

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (~wpcir),
        .count (stall_cnt)
    );

    sat_counter #(.CW(CW)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (r_ebubble),
        .count (bubble_cnt)
    );

    assign ewreg   = r_e_ctrl.wreg;
    assign em2reg  = r_e_ctrl.m2reg;
    assign ewmem   = r_e_ctrl.wmem;
    assign ealuc   = r_e_ctrl.aluc;
    assign ealuimm = r_e_ctrl.aluimm;
    assign eshift  = r_e_ctrl.shift;
    assign ejal    = r_e_ctrl.jal;
    assign ern     = r_e_rn;
    assign ebubble = r_ebubble;
    assign mwreg   = r_m_wreg;
    assign mm2reg  = r_m_m2reg;
    assign mwmem   = r_m_wmem;
    assign mrn     = r_m_rn;
    assign wwreg   = r_w_wreg;
    assign wm2reg  = r_w_m2reg;
    assign wrn     = r_w_rn;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs with a 4-bit counter width so that
// saturation is reachable quickly.
module tb_pipe_ctrl_regs;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          d_wreg, d_m2reg, d_wmem, d_regrt, d_jal;
    logic [3:0]    d_aluc;
    logic          d_aluimm, d_shift;
    logic [RW-1:0] d_rt, d_rd;
    logic [1:0]    d_pcsource;
    logic          wpcir;
    logic          ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ebubble;
    logic [3:0]    ealuc;
    logic [RW-1:0] ern, mrn, wrn;
    logic          mwreg, mm2reg, mwmem, wwreg, wm2reg;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pipe_ctrl_regs #(.RW(RW), .CW(CW), .LINK_REG(31)) dut (
        .clock      (clock),
        .reset      (reset),
        .d_wreg     (d_wreg),
        .d_m2reg    (d_m2reg),
        .d_wmem     (d_wmem),
        .d_regrt    (d_regrt),
        .d_jal      (d_jal),
        .d_aluc     (d_aluc),
        .d_aluimm   (d_aluimm),
        .d_shift    (d_shift),
        .d_rt       (d_rt),
        .d_rd       (d_rd),
        .d_pcsource (d_pcsource),
        .wpcir      (wpcir),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .ewmem      (ewmem),
        .ealuc      (ealuc),
        .ealuimm    (ealuimm),
        .eshift     (eshift),
        .ejal       (ejal),
        .ern        (ern),
        .ebubble    (ebubble),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .mrn        (mrn),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wrn        (wrn),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ewreg"},      32'(ewreg),      32'd0);
        check({tag, ".em2reg"},     32'(em2reg),     32'd0);
        check({tag, ".ewmem"},      32'(ewmem),      32'd0);
        check({tag, ".ealuc"},      32'(ealuc),      32'd0);
        check({tag, ".ealuimm"},    32'(ealuimm),    32'd0);
        check({tag, ".eshift"},     32'(eshift),     32'd0);
        check({tag, ".ejal"},       32'(ejal),       32'd0);
        check({tag, ".ern"},        32'(ern),        32'd0);
        check({tag, ".ebubble"},    32'(ebubble),    32'd0);
        check({tag, ".mwreg"},      32'(mwreg),      32'd0);
        check({tag, ".mm2reg"},     32'(mm2reg),     32'd0);
        check({tag, ".mwmem"},      32'(mwmem),      32'd0);
        check({tag, ".mrn"},        32'(mrn),        32'd0);
        check({tag, ".wwreg"},      32'(wwreg),      32'd0);
        check({tag, ".wm2reg"},     32'(wm2reg),     32'd0);
        check({tag, ".wrn"},        32'(wrn),        32'd0);
        check({tag, ".stall_cnt"},  32'(stall_cnt),  32'd0);
        check({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'd0);
    endtask

    // Idle decode slot, pipeline advancing.
    task automatic clear_d();
        d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_regrt = 0; d_jal = 0;
        d_aluc = 4'd0; d_aluimm = 0; d_shift = 0;
        d_rt = '0; d_rd = '0; d_pcsource = 2'b00; wpcir = 1'b1;
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_d();
        reset = 1'b1;
        #12;
        check_all_zero("reset");
        reset = 1'b0;

        // Propagation through all three boundaries (rt selected over rd).
        d_wreg = 1; d_regrt = 1; d_rt = 5'd9; d_rd = 5'd2; d_wmem = 1;
        d_aluc = 4'b0101; d_aluimm = 1; d_shift = 1;
        tick();
        check("prop.e.ern",     32'(ern),     32'd9);
        check("prop.e.ewreg",   32'(ewreg),   32'd1);
        check("prop.e.ewmem",   32'(ewmem),   32'd1);
        check("prop.e.ealuc",   32'(ealuc),   32'h5);
        check("prop.e.ealuimm", 32'(ealuimm), 32'd1);
        check("prop.e.eshift",  32'(eshift),  32'd1);
        check("prop.e.ebubble", 32'(ebubble), 32'd0);
        clear_d();
        tick();
        check("prop.m.mrn",   32'(mrn),   32'd9);
        check("prop.m.mwreg", 32'(mwreg), 32'd1);
        check("prop.m.mwmem", 32'(mwmem), 32'd1);
        check("prop.m.ewreg", 32'(ewreg), 32'd0);
        check("prop.m.ern",   32'(ern),   32'd0);
        tick();
        check("prop.w.wrn",   32'(wrn),   32'd9);
        check("prop.w.wwreg", 32'(wwreg), 32'd1);
        check("prop.w.mrn",   32'(mrn),   32'd0);
        tick();
        check("prop.flush.wwreg", 32'(wwreg), 32'd0);

        // jal forces the link register and a taken transfer raises ebubble.
        d_jal = 1; d_wreg = 1; d_rd = 5'd4; d_rt = 5'd5; d_pcsource = 2'b11;
        tick();
        check("jal.ern",        32'(ern),        32'd31);
        check("jal.ejal",       32'(ejal),       32'd1);
        check("jal.ewreg",      32'(ewreg),      32'd1);
        check("jal.ebubble",    32'(ebubble),    32'd1);
        check("jal.bubble_cnt", 32'(bubble_cnt), 32'd0);
        clear_d();
        tick();
        check("jal.bubble_cnt1", 32'(bubble_cnt), 32'd1);
        check("jal.ebubble0",    32'(ebubble),    32'd0);
        check("jal.mrn",         32'(mrn),        32'd31);

        // Load followed by a one-cycle load-use stall; the stalled slot
        // carries a branch and X fields that must not leak.
        d_wreg = 1; d_m2reg = 1; d_regrt = 1; d_rt = 5'd8; d_aluimm = 1;
        tick();
        check("lw.em2reg", 32'(em2reg), 32'd1);
        check("lw.ern",    32'(ern),    32'd8);
        wpcir = 0; d_wreg = 1; d_m2reg = 1; d_regrt = 0; d_rd = 5'd3;
        d_rt = 'x; d_aluc = 'x; d_shift = 'x; d_pcsource = 2'b01;
        tick();
        check("stall.ewreg",     32'(ewreg),     32'd0);
        check("stall.em2reg",    32'(em2reg),    32'd0);
        check("stall.ealuc",     32'(ealuc),     32'd0);
        check("stall.ealuimm",   32'(ealuimm),   32'd0);
        check("stall.eshift",    32'(eshift),    32'd0);
        check("stall.ern",       32'(ern),       32'd0);
        check("stall.ebubble",   32'(ebubble),   32'd0);
        check("stall.mm2reg",    32'(mm2reg),    32'd1);
        check("stall.mwreg",     32'(mwreg),     32'd1);
        check("stall.mrn",       32'(mrn),       32'd8);
        check("stall.stall_cnt", 32'(stall_cnt), 32'd1);
        clear_d();
        tick();
        check("stall.wm2reg",     32'(wm2reg),     32'd1);
        check("stall.wrn",        32'(wrn),        32'd8);
        check("stall.mm2reg0",    32'(mm2reg),     32'd0);
        check("stall.stall_cnt1", 32'(stall_cnt),  32'd1);
        check("stall.bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Both counters advance on the same edge.
        d_pcsource = 2'b01;
        tick();
        check("both.ebubble", 32'(ebubble), 32'd1);
        clear_d();
        wpcir = 0;
        tick();
        check("both.stall_cnt",  32'(stall_cnt),  32'd2);
        check("both.bubble_cnt", 32'(bubble_cnt), 32'd2);

        // Long stall: stall_cnt climbs to 15 and sticks there.
        for (int i = 0; i < 12; i++) tick();
        check("sat.stall_cnt14", 32'(stall_cnt), 32'd14);
        for (int i = 0; i < 8; i++) tick();
        check("sat.stall_cnt15",  32'(stall_cnt),  32'd15);
        check("sat.bubble_cnt",   32'(bubble_cnt), 32'd2);

        // Asynchronous reset between edges clears every stage at once.
        clear_d();
        d_wreg = 1; d_rd = 5'd7;
        tick();
        tick();
        tick();
        check("pre_rst.wrn",   32'(wrn),   32'd7);
        check("pre_rst.wwreg", 32'(wwreg), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
